// File: rtl/boot_loader.sv
// Boot loader: copies LENGTH words from a parallel EEPROM into RAM
// after reset, one word per READ/SETUP/PULSE/HOLD sequence.
module boot_loader #(
  parameter int ROM_ADDR_WIDTH = 17,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int WIDTH          = 8,
  parameter int LENGTH         = 65536,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  output logic [ROM_ADDR_WIDTH-1:0] ROM_ADDR,
  output logic                      ROM_N_OE,
  input  logic [WIDTH-1:0]          ROM_DATA,
  output logic [RAM_ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [WIDTH-1:0]          RAM_DATA,
  output logic                      BOOT_N_WE,
  output logic                      N_BOOTED
);

  // Index must hold LENGTH-1 without wrapping, even when LENGTH is 2^N.
  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LENGTH - 1);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_READ,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_wait;
  logic [WIDTH-1:0] r_data;

  // Copy sequencer: settle, capture, strobe, advance; reset overrides all.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_READ;
      r_idx   <= '0;
      r_wait  <= WAIT_LD;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        S_READ: begin
          if (r_wait == 4'd0) begin
            r_data  <= ROM_DATA;
            r_state <= S_SETUP;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_SETUP: r_state <= S_PULSE;
        S_PULSE: r_state <= S_HOLD;
        S_HOLD: begin
          r_wait <= WAIT_LD;
          if (r_idx == LAST) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_READ;
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_READ;
      endcase
    end
  end

  // Outputs decode registered state; RST forces the idle/reset values
  // immediately so an interrupted PULSE never leaves the strobe low.
  logic w_read;
  logic w_pulse;
  logic w_done;

  assign w_read  = (r_state == S_READ);
  assign w_pulse = (r_state == S_PULSE);
  assign w_done  = (r_state == S_DONE);

  assign ROM_ADDR  = RST ? '0 : ROM_ADDR_WIDTH'(r_idx);
  assign RAM_ADDR  = RST ? '0 : RAM_ADDR_WIDTH'(r_idx);
  assign RAM_DATA  = RST ? '0 : r_data;
  assign ROM_N_OE  = RST | ~w_read;
  assign BOOT_N_WE = RST | ~w_pulse;
  assign N_BOOTED  = RST | ~w_done;

endmodule
